// File: rtl/ru_ctrl_pkg.sv
// Shared types and constants for the register-unit write-port control logic.
//   XLEN    : data width of a register write
//   REG_W   : register index width
//   NREGS   : number of architectural registers (x0 is hardwired zero)
//   ru_wr_t : one pending register write (destination + data)
package ru_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int NREGS = 32;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } ru_wr_t;

endpackage

// File: rtl/ru_wr_fifo.sv
// Small FIFO of pending LU register writes.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : enqueue push_data (ignored while full)
//   push_data  : entry to enqueue
//   pop        : dequeue the head (ignored while empty)
//   head       : current head entry (valid only when !empty)
//   full/empty : occupancy flags
module ru_wr_fifo
    import ru_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  ru_wr_t push_data,
    input  logic   pop,
    output ru_wr_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ru_wr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped here; the producer sees lu_ready low.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == {CNT_W{1'b0}});
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ru_wr_arbiter.sv
// Arbitrates the single register-unit write port between WB (always first) and
// buffered LU results, tracks LU-pending destinations, and stalls ID on hazards
// against them or when LU results have been starved too long.
//   clk, rst                : clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data  : WB stage write (no back-pressure)
//   lu_valid/lu_ready       : LU result handshake; lu_rd/lu_data the result
//   iss_*                   : ID-stage instruction being considered for issue
//   stall                   : freeze IF/ID, bubble into EX
//   RUwrite/rd/RUdw         : register-unit write port
module ru_wr_arbiter
    import ru_ctrl_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [REG_W-1:0] lu_rd,
    input  logic [XLEN-1:0]  lu_data,
    input  logic             iss_valid,
    input  logic             iss_lu,
    input  logic [REG_W-1:0] iss_rs1,
    input  logic [REG_W-1:0] iss_rs2,
    input  logic [REG_W-1:0] iss_rd,
    output logic             stall,
    output logic             RUwrite,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  RUdw
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    ru_wr_t            head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wb_eff;
    logic              hz;
    logic              drain;
    logic              busy_set;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_next;

    ru_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{rd: lu_rd, data: lu_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A WB write to x0 is a no-op and leaves the port free for the FIFO.
    assign wb_eff   = wb_valid & (wb_rd != {REG_W{1'b0}});
    assign lu_ready = ~rst & ~full;
    assign push     = lu_valid & lu_ready;
    assign hz       = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
    assign drain    = (starve_cnt == SC_W'(STARVE_MAX));
    assign stall    = ~rst & (hz | drain);
    assign busy_set = iss_valid & iss_lu & ~stall & (iss_rd != {REG_W{1'b0}});

    // Write-port mux: WB first, else drain FIFO head; outputs forced idle in reset.
    always_comb begin
        RUwrite = 1'b0;
        rd      = {REG_W{1'b0}};
        RUdw    = {XLEN{1'b0}};
        pop     = 1'b0;
        if (rst) begin
            pop = 1'b0;
        end else if (wb_eff) begin
            RUwrite = 1'b1;
            rd      = wb_rd;
            RUdw    = wb_data;
        end else if (!empty) begin
            pop     = 1'b1;
            RUwrite = (head.rd != {REG_W{1'b0}});
            rd      = head.rd;
            RUdw    = head.data;
        end else begin
            pop = 1'b0;
        end
    end

    // Scoreboard next state: issue set beats pop clear on the same index; x0 stays 0.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < NREGS; i++) begin
            busy_next[i] = (busy_set && (iss_rd == REG_W'(i))) ? 1'b1 :
                           (pop && (head.rd == REG_W'(i)))     ? 1'b0 : busy[i];
        end
        busy_next[0] = 1'b0;
    end

    // Starvation counter: counts WB-blocked cycles with pending LU results.
    always_comb begin
        starve_next = starve_cnt;
        if (empty || pop) begin
            starve_next = {SC_W{1'b0}};
        end else if (wb_eff && !drain) begin
            starve_next = starve_cnt + SC_W'(1);
        end else begin
            starve_next = starve_cnt;
        end
    end

    // State registers for scoreboard and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= {NREGS{1'b0}};
            starve_cnt <= {SC_W{1'b0}};
        end else begin
            busy       <= busy_next;
            starve_cnt <= starve_next;
        end
    end

endmodule

// File: tb/tb_ru_wr_arbiter.sv
// Directed testbench for ru_wr_arbiter (DEPTH=2, STARVE_MAX=8).
// Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
module tb_ru_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid, lu_valid, lu_ready, iss_valid, iss_lu, stall, RUwrite;
    logic [4:0]  wb_rd, lu_rd, iss_rs1, iss_rs2, iss_rd, rd;
    logic [31:0] wb_data, lu_data, RUdw;

    int errors = 0;
    int checks = 0;

    ru_wr_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_lu(iss_lu), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .stall(stall), .RUwrite(RUwrite), .rd(rd), .RUdw(RUdw)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
        iss_valid = 1'b0; iss_lu = 1'b0;
        iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
    endtask

    task automatic lu(input logic [4:0] r, input logic [31:0] d);
        lu_valid = 1'b1; lu_rd = r; lu_data = d;
    endtask

    task automatic iss(input logic l, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        iss_valid = 1'b1; iss_lu = l; iss_rs1 = s1; iss_rs2 = s2; iss_rd = d;
    endtask

    initial begin
        idle();
        // Reset holds outputs idle even with a WB write presented.
        wb(5'd3, 32'h1);
        settle();
        check_eq("rst_ruwrite", {31'd0, RUwrite}, 32'd0);
        check_eq("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        check_eq("post_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        check_eq("post_rst_ruwrite", {31'd0, RUwrite}, 32'd0);

        // Priority: issue LU rd=7 and push its result; empty FIFO must not bypass.
        iss(1'b1, 5'd0, 5'd0, 5'd7);
        lu(5'd7, 32'h1234);
        settle();
        check_eq("nobypass_ruwrite", {31'd0, RUwrite}, 32'd0);
        tick(); idle();
        wb(5'd3, 32'hAAAA5555);
        iss(1'b0, 5'd7, 5'd0, 5'd0);
        settle();
        check_eq("prio_ruwrite", {31'd0, RUwrite}, 32'd1);
        check_eq("prio_rd", {27'd0, rd}, 32'd3);
        check_eq("prio_data", RUdw, 32'hAAAA5555);
        check_eq("busy7_stall", {31'd0, stall}, 32'd1);
        tick(); idle();
        settle();
        check_eq("pop7_ruwrite", {31'd0, RUwrite}, 32'd1);
        check_eq("pop7_rd", {27'd0, rd}, 32'd7);
        check_eq("pop7_data", RUdw, 32'h1234);
        tick(); idle();
        iss(1'b0, 5'd7, 5'd0, 5'd0);
        settle();
        check_eq("busy7_cleared", {31'd0, stall}, 32'd0);
        check_eq("empty_ruwrite", {31'd0, RUwrite}, 32'd0);

        // RAW/WAW on x10.
        tick(); idle();
        iss(1'b1, 5'd0, 5'd0, 5'd10);
        settle();
        check_eq("iss10_stall", {31'd0, stall}, 32'd0);
        tick(); idle();
        iss(1'b0, 5'd10, 5'd0, 5'd11);
        settle();
        check_eq("raw10_stall", {31'd0, stall}, 32'd1);
        tick(); idle();
        iss(1'b1, 5'd1, 5'd2, 5'd10);
        settle();
        check_eq("waw10_stall", {31'd0, stall}, 32'd1);
        tick(); idle();
        iss(1'b0, 5'd10, 5'd0, 5'd11);
        lu(5'd10, 32'hCAFE);
        settle();
        check_eq("raw10_hold", {31'd0, stall}, 32'd1);
        tick(); idle();
        iss(1'b0, 5'd10, 5'd0, 5'd11);
        settle();
        check_eq("pop10_rd", {27'd0, rd}, 32'd10);
        check_eq("pop10_data", RUdw, 32'hCAFE);
        tick(); idle();
        iss(1'b0, 5'd10, 5'd0, 5'd11);
        settle();
        check_eq("raw10_released", {31'd0, stall}, 32'd0);

        // x0: WB to x0 frees the slot for the FIFO head.
        tick(); idle();
        lu(5'd4, 32'h44);
        iss(1'b1, 5'd0, 5'd0, 5'd0);
        tick(); idle();
        wb(5'd0, 32'hDEAD);
        settle();
        check_eq("x0_ruwrite", {31'd0, RUwrite}, 32'd1);
        check_eq("x0_rd", {27'd0, rd}, 32'd4);
        check_eq("x0_data", RUdw, 32'h44);
        // LU result to x0 pops but does not write.
        tick(); idle();
        lu(5'd0, 32'h99);
        tick(); idle();
        iss(1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        check_eq("lu_x0_ruwrite", {31'd0, RUwrite}, 32'd0);
        check_eq("iss_x0_stall", {31'd0, stall}, 32'd0);

        // Full FIFO and starvation with WB busy every cycle.
        tick(); idle();
        for (int c = 1; c <= 11; c++) begin
            wb(5'd1, 32'(c));
            if (c == 1) lu(5'd20, 32'h20);
            else if (c == 2) lu(5'd21, 32'h21);
            else lu(5'd22, 32'h22);
            settle();
            if (c == 3) check_eq("full_lu_ready", {31'd0, lu_ready}, 32'd0);
            if (c == 9) check_eq("starve7_stall", {31'd0, stall}, 32'd0);
            if (c == 10) check_eq("drain_stall", {31'd0, stall}, 32'd1);
            if (c == 11) check_eq("drain_hold", {31'd0, stall}, 32'd1);
            tick(); idle();
        end
        settle();
        check_eq("drain_pop_rd", {27'd0, rd}, 32'd20);
        check_eq("drain_pop_data", RUdw, 32'h20);
        tick(); idle();
        settle();
        check_eq("drain_released", {31'd0, stall}, 32'd0);
        check_eq("second_pop_rd", {27'd0, rd}, 32'd21);
        check_eq("not_full_lu_ready", {31'd0, lu_ready}, 32'd1);
        tick(); idle();
        settle();
        check_eq("dropped_push", {31'd0, RUwrite}, 32'd0);

        // Reset mid-burst: 2 entries queued, busy[5] set.
        tick(); idle();
        wb(5'd1, 32'h1);
        iss(1'b1, 5'd0, 5'd0, 5'd5);
        lu(5'd5, 32'h55);
        tick(); idle();
        wb(5'd1, 32'h2);
        lu(5'd6, 32'h66);
        tick(); idle();
        wb(5'd1, 32'h3);
        iss(1'b0, 5'd5, 5'd0, 5'd0);
        lu(5'd7, 32'h77);
        settle();
        check_eq("pre_rst_busy5", {31'd0, stall}, 32'd1);
        check_eq("pre_rst_full", {31'd0, lu_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ruwrite", {31'd0, RUwrite}, 32'd0);
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        iss(1'b0, 5'd5, 5'd6, 5'd7);
        settle();
        check_eq("rel_lu_ready", {31'd0, lu_ready}, 32'd1);
        check_eq("rel_busy_clear", {31'd0, stall}, 32'd0);
        check_eq("rel_fifo_empty", {31'd0, RUwrite}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
